// File: rtl/seg_pkg.sv
// seg_pkg: glyph type, key-code constants and the 7-segment decode table.
package seg_pkg;
    typedef logic [4:0] glyph_t;
    localparam glyph_t GLYPH_BLANK = 5'd16;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;
    localparam logic [7:0] SEG_TABLE [17] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h76, 8'h49, 8'h40
    };
    function automatic logic [7:0] glyph_to_seg(input glyph_t g);
        return (g > GLYPH_BLANK) ? 8'h40 : SEG_TABLE[g];
    endfunction
endpackage

// File: rtl/key_sampler.sv
// key_sampler: synchronises key_pressed, samples it on a prescaled tick and
// flags a press on a 0->1 change between ticks.
module key_sampler #(
    parameter int SAMPLE_DIV = 32001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_pressed,
    output logic       press_accept,
    output logic [3:0] code
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_prev;
    logic          w_tick;
    assign w_tick       = (r_cnt == LAST);
    assign press_accept = w_tick & r_sync[1] & ~r_prev;
    assign code         = key_code;
    // sync flops and prev reset high so a key held through reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], key_pressed};
            r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) r_prev <= r_sync[1];
        end
    end
endmodule

// File: rtl/typewriter_display.sv
// typewriter_display: shifts typed key codes into a NUM_DIGITS 7-segment buffer.
// Define TYPEWRITER_EDIT_KEYS_EN to make '*' backspace and '#' clear.
module typewriter_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SAMPLE_DIV = 32001
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3:0]                      key_code,
    input  logic                            key_pressed,
    output logic [8*NUM_DIGITS-1:0]         segs_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0] char_count,
    output logic                            key_event
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(NUM_DIGITS);
    glyph_t        r_buf [NUM_DIGITS];
    logic [CW-1:0] r_cnt;
    logic          r_event;
    glyph_t        w_typed [NUM_DIGITS];
    glyph_t        w_next [NUM_DIGITS];
    logic [CW-1:0] w_cnt_next;
    logic          w_press;
    logic [3:0]    w_code;
    key_sampler #(.SAMPLE_DIV(SAMPLE_DIV)) u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_code     (key_code),
        .key_pressed  (key_pressed),
        .press_accept (w_press),
        .code         (w_code)
    );
    always_comb begin
        for (int i = 0; i < NUM_DIGITS - 1; i++) w_typed[i] = r_buf[i+1];
        w_typed[NUM_DIGITS-1] = {1'b0, w_code};
    end
`ifdef TYPEWRITER_EDIT_KEYS_EN
    glyph_t w_erased [NUM_DIGITS];
    always_comb begin
        w_erased[0] = GLYPH_BLANK;
        for (int i = 1; i < NUM_DIGITS; i++) w_erased[i] = r_buf[i-1];
    end
    always_comb begin
        w_next     = r_buf;
        w_cnt_next = r_cnt;
        if (w_press && w_code == KEY_HASH) begin
            w_next     = '{default: GLYPH_BLANK};
            w_cnt_next = '0;
        end else if (w_press && w_code == KEY_STAR) begin
            if (r_cnt != '0) begin
                w_next     = w_erased;
                w_cnt_next = r_cnt - 1'b1;
            end
        end else if (w_press) begin
            w_next     = w_typed;
            w_cnt_next = (r_cnt == MAXC) ? r_cnt : r_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        w_next     = w_press ? w_typed : r_buf;
        w_cnt_next = (w_press && r_cnt != MAXC) ? r_cnt + 1'b1 : r_cnt;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '{default: GLYPH_BLANK};
            r_cnt   <= '0;
            r_event <= 1'b0;
        end else begin
            r_buf   <= w_next;
            r_cnt   <= w_cnt_next;
            r_event <= w_press;
        end
    end
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        assign segs_out[8*g +: 8] = glyph_to_seg(r_buf[g]);
    end
    assign char_count = r_cnt;
    assign key_event  = r_event;
endmodule

// File: tb/tb_typewriter_display.sv
// tb_typewriter_display: directed checks of typing, saturation, edit keys and reset behaviour.
module tb_typewriter_display;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_pressed = 1'b0;
    logic [31:0] segs_out;
    logic [2:0]  char_count;
    logic        key_event;
    int          errors = 0;
    int          checks = 0;
    int          ev_total = 0;
    int          ev_run = 0;
    int          ev_max_run = 0;
    int          ev_base;

    typewriter_display #(.NUM_DIGITS(4), .SAMPLE_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .segs_out    (segs_out),
        .char_count  (char_count),
        .key_event   (key_event)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event) begin
            ev_total++;
            ev_run++;
            if (ev_run > ev_max_run) ev_max_run = ev_run;
        end else begin
            ev_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_code    = code;
        key_pressed = 1'b1;
        repeat (8) @(negedge clk);
        key_pressed = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        do_reset();
        ev_base = ev_total;
        repeat (20) @(negedge clk);
        chk("reset_segs", segs_out, 32'h40404040);
        chk("reset_count", 32'(char_count), 32'd0);
        chk("reset_no_event", 32'(ev_total - ev_base), 32'd0);

        ev_base = ev_total;
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("type123_segs", segs_out, 32'h4F5B0640);
        chk("type123_count", 32'(char_count), 32'd3);
        chk("type123_events", 32'(ev_total - ev_base), 32'd3);
        chk("event_width", 32'(ev_max_run), 32'd1);

        press(4'd5);
        press(4'd10);
        chk("overflow_segs", segs_out, 32'h776D4F5B);
        chk("overflow_count", 32'(char_count), 32'd4);

`ifdef TYPEWRITER_EDIT_KEYS_EN
        do_reset();
        press(4'd1);
        press(4'd2);
        press(4'd14);
        chk("bksp_segs", segs_out, 32'h06404040);
        chk("bksp_count", 32'(char_count), 32'd1);
        press(4'd15);
        chk("clear_segs", segs_out, 32'h40404040);
        chk("clear_count", 32'(char_count), 32'd0);
        ev_base = ev_total;
        press(4'd14);
        chk("bksp_empty_segs", segs_out, 32'h40404040);
        chk("bksp_empty_count", 32'(char_count), 32'd0);
        chk("bksp_empty_event", 32'(ev_total - ev_base), 32'd1);
`else
        do_reset();
        press(4'd14);
        chk("star_segs", segs_out, 32'h76404040);
        chk("star_count", 32'(char_count), 32'd1);
        press(4'd15);
        chk("hash_segs", segs_out, 32'h49764040);
        chk("hash_count", 32'(char_count), 32'd2);
`endif

        @(negedge clk);
        key_code    = 4'd7;
        key_pressed = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        ev_base = ev_total;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_reset_segs", segs_out, 32'h40404040);
        chk("held_reset_count", 32'(char_count), 32'd0);
        chk("held_reset_event", 32'(ev_total - ev_base), 32'd0);
        key_pressed = 1'b0;
        repeat (8) @(negedge clk);
        press(4'd7);
        chk("repress_segs", segs_out, 32'h07404040);
        chk("repress_count", 32'(char_count), 32'd1);

        press(4'd8);
        chk("pre_async_segs", segs_out, 32'h7F074040);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_segs", segs_out, 32'h40404040);
        chk("async_reset_count", 32'(char_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/typewriter_display.md
# typewriter_display

Parametrised multi-digit successor to the single-digit key display. Sits between `keyboard_controller` and the 7-segment indicator bank and turns each accepted key press into a typed character. New characters enter at the rightmost indicator, older characters shift left, and the oldest drops off when the display is full. Optional editing keys (backspace, clear) are compiled in by macro.

## Interface
- `NUM_DIGITS`, default 4: number of indicators, minimum 1.
- `SAMPLE_DIV`, default 32001: `clk` cycles per key-sample tick, minimum 2.
- `clk` in, 1 bit: system clock.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `key_code` in, 4 bits: key code from `keyboard_controller`.
  - 0–9 are digits, 10–13 are A–d, 14 is `*`, 15 is `#`.
  - Must be stable while `key_pressed` is high.
- `key_pressed` in, 1 bit: asynchronous "key held" level.
- `segs_out` out, `8*NUM_DIGITS` bits: segment bytes in hgfedcba order.
  - Byte 0 (`[7:0]`) is the leftmost indicator; the top byte is the rightmost.
- `char_count` out, `$clog2(NUM_DIGITS+1)` bits: number of non-blank positions, 0 to `NUM_DIGITS`.
- `key_event` out, 1 bit: one-`clk` pulse for each accepted press.

## Operation
- **Synchroniser:** `key_pressed` passes through a 2-flop synchroniser on `clk`.
- **Prescaler:**
  - Counts 0 to `SAMPLE_DIV-1` and wraps.
  - `tick` is high for one cycle when the count equals `SAMPLE_DIV-1`.
- **Press detection:**
  - On each `tick`, the synchronised level is compared with `prev`, then `prev` is updated.
  - A press is accepted when the level is 1 and `prev` is 0.
  - `key_code` is sampled in the same cycle.
- **Buffer:**
  - `NUM_DIGITS` glyphs, 5 bits each. Values 0–15 are characters; 16 is BLANK, shown as `-` (0x40).
  - Segment table: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E `*`=0x76 `#`=0x49.
- **Type** (any accepted code not handled as an edit key):
  - Every position takes its right neighbour's glyph; the rightmost takes the new code.
  - The leftmost glyph is discarded.
  - `char_count` increments and saturates at `NUM_DIGITS`.
- **`segs_out`:** combinational decode of the buffer registers; no extra pipeline stage.
- **Reset values:**
  - All glyphs BLANK, so `segs_out` is all bytes 0x40.
  - `char_count` is 0, `key_event` is 0, prescaler is 0.
  - Both synchroniser flops and `prev` reset to 1, so a key held through reset is ignored until it is released and pressed again.
- **Reset mid-operation:** immediate return to the reset state; any pending press is lost.

## Timing
- A change on `key_pressed` reaches the synchronised level after 2 `clk` edges.
- It is then evaluated at the next `tick`, which is at most `SAMPLE_DIV` cycles later.
- On the `clk` edge ending a `tick` cycle with an accepted press:
  - The buffer and `char_count` update.
  - `key_event` is high for exactly that following cycle.
- Presses shorter than the sample period can be missed; this is intended and acts as debounce.
- At most one buffer update per `tick`; there are no simultaneous-event cases.

## Configuration
- **`TYPEWRITER_EDIT_KEYS_EN` defined:**
  - Code 14 (`*`) is backspace. Every position takes its left neighbour's glyph, the leftmost becomes BLANK, and `char_count` decrements. When empty, the buffer is unchanged and `char_count` stays 0.
  - Code 15 (`#`) is clear: all glyphs become BLANK and `char_count` becomes 0.
  - `key_event` still pulses for both keys.
- **Undefined:** codes 14 and 15 are typed as ordinary characters.

## Structure
- **Package `seg_pkg`** holds:
  - `glyph_t` (logic [4:0]) and the constant `GLYPH_BLANK` = 16.
  - Key-code constants `KEY_STAR` = 14 and `KEY_HASH` = 15.
  - The 17-entry segment constant table and a `glyph_to_seg` function.
- **Sub-module `key_sampler`** contains the synchroniser, prescaler, `prev` register and edge detect. It outputs `press_accept` and the sampled `key_code`.
- **Top level** contains the buffer, count and decode.

## Test plan
Bench uses `SAMPLE_DIV`=4, `NUM_DIGITS`=4, with each press held ≥8 cycles and released ≥8 cycles.
- Reset, then no stimulus → `segs_out`=0x40404040, `char_count`=0, `key_event` never pulses.
- Press 1, 2, 3 → `segs_out`=0x4F5B0640, `char_count`=3, three single-cycle `key_event` pulses.
- Press 1, 2, 3, 5, A → `segs_out`=0x776D4F5B (oldest digit dropped), `char_count`=4 (saturated).
- With `TYPEWRITER_EDIT_KEYS_EN`, type 1, 2, then `*` → `segs_out`=0x06404040, `char_count`=1. Then `#` → all 0x40, `char_count`=0. Then `*` on the empty buffer → unchanged, `key_event` pulses.
- Without the macro, press `*` → rightmost byte is 0x76, `char_count`=1.
- Hold `key_pressed` high across `rst_n` deassertion → no character typed until release and re-press. Also assert `rst_n` low mid-session → `segs_out` returns to 0x40404040 asynchronously.
